hilo_ctrl: RTL and testbench

- Sequencing stage for the HI/LO architectural registers.
- Accepts MULT/DIV/MTHI/MTLO requests from the control unit and issues one-cycle start pulses to the multiplier and divider.
- Waits for the done strobe, then captures the 64-bit result into HI/LO.
- Provides the busy/ready handshake used to stall MFHI/MFLO and further HI/LO ops.

---
 rtl/hilo_if.sv | 41 ++++
 rtl/hilo_ctrl.sv | 123 ++++++++++++
 tb/tb_hilo_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/hilo_if.sv
// HI/LO sequencing bundle: request channel, multiplier/divider links, HI/LO and status outputs.
// Latency: none (wiring only).
// Backpressure: op_ready gates op_valid; requests are never queued.
interface hilo_if;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] op_data;
    logic        op_ready;
    logic        mult_start;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        mult_done;
    logic        div_start;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        div_zero_err;
    logic        timeout_err;

    // Environment side: control unit plus the arithmetic units.
    modport master (
        output op_valid, op_code, op_data,
        output mult_hi, mult_lo, mult_done,
        output div_hi, div_lo, div_done, div_zero,
        input  op_ready, mult_start, div_start,
        input  hi, lo, busy, div_zero_err, timeout_err
    );

    // HI/LO controller side.
    modport slave (
        input  op_valid, op_code, op_data,
        input  mult_hi, mult_lo, mult_done,
        input  div_hi, div_lo, div_done, div_zero,
        output op_ready, mult_start, div_start,
        output hi, lo, busy, div_zero_err, timeout_err
    );
endinterface

// File: rtl/hilo_ctrl.sv
// Sequences MULT/DIV/MTHI/MTLO into the HI/LO registers with start pulses and done capture.
// Latency: MTHI/MTLO 1 cycle; MULT/DIV 2 + unit latency cycles from the accept edge.
// Backpressure: op_ready low while an operation is in flight; requests then are dropped.
module hilo_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic  clk,
    input  logic  reset,
    hilo_if.slave bus
);
    localparam logic [1:0] OP_MULT = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;

    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        M_START = 3'd1,
        M_WAIT  = 3'd2,
        D_START = 3'd3,
        D_WAIT  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          dz_err_q, dz_err_d;
    logic          to_err_q, to_err_d;

    // State, wait counter, HI/LO and error pulses; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_err_q <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_err_q <= dz_err_d;
            to_err_q <= to_err_d;
        end
    end

    // Next state: accept only in IDLE; a done strobe beats a timeout in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_err_d = 1'b0;
        to_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    if (bus.op_code == OP_MULT) begin
                        state_d = M_START;
                    end else if (bus.op_code == OP_DIV) begin
                        state_d = D_START;
                    end else if (bus.op_code == OP_MTHI) begin
                        hi_d = bus.op_data;
                    end else begin
                        lo_d = bus.op_data;
                    end
                end
            end
            M_START: begin
                state_d = M_WAIT;
                cnt_d   = '0;
            end
            D_START: begin
                state_d = D_WAIT;
                cnt_d   = '0;
            end
            M_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.mult_done) begin
                    hi_d    = bus.mult_hi;
                    lo_d    = bus.mult_lo;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    to_err_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            D_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.div_done) begin
                    if (bus.div_zero) begin
                        dz_err_d = 1'b1;
                    end else begin
                        hi_d = bus.div_hi;
                        lo_d = bus.div_lo;
                    end
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    to_err_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so start pulses last exactly one cycle.
    assign bus.op_ready     = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.mult_start   = (state_q == M_START);
    assign bus.div_start    = (state_q == D_START);
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.div_zero_err = dz_err_q;
    assign bus.timeout_err  = to_err_q;
endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;
    localparam int TO = 40;

    logic clk;
    logic reset;
    hilo_if bus();

    hilo_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0;
    int nmis = 0;
    int start_cnt = 0;

    // Behavioural model: an outstanding op is tracked by its age in cycles since acceptance.
    // Age 1 is the start cycle; age a>=2 is wait cycle number a-1.
    logic [31:0] m_hi, m_lo;
    logic        m_act, m_kind, m_dz, m_to;
    int          m_age;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= 0; m_lo <= 0; m_act <= 0; m_kind <= 0; m_age <= 0; m_dz <= 0; m_to <= 0;
        end else begin
            m_dz <= 0;
            m_to <= 0;
            if (!m_act) begin
                if (bus.op_valid) begin
                    if (bus.op_code == 2) m_hi <= bus.op_data;
                    else if (bus.op_code == 3) m_lo <= bus.op_data;
                    else begin m_act <= 1; m_kind <= bus.op_code[0]; m_age <= 1; end
                end
            end else if (m_age == 1) begin
                m_age <= 2;
            end else begin
                if (!m_kind && bus.mult_done) begin
                    m_hi <= bus.mult_hi; m_lo <= bus.mult_lo; m_act <= 0;
                end else if (m_kind && bus.div_done) begin
                    if (bus.div_zero) m_dz <= 1;
                    else begin m_hi <= bus.div_hi; m_lo <= bus.div_lo; end
                    m_act <= 0;
                end else if (m_age - 1 == TO) begin
                    m_to <= 1; m_act <= 0;
                end else begin
                    m_age <= m_age + 1;
                end
            end
        end
    end

    task automatic check_cycle();
        logic exp_ms, exp_ds, ok;
        exp_ms = m_act && !m_kind && (m_age == 1);
        exp_ds = m_act && m_kind && (m_age == 1);
        ok = (bus.hi === m_hi) && (bus.lo === m_lo) && (bus.busy === m_act) &&
             (bus.op_ready === !m_act) && (bus.mult_start === exp_ms) &&
             (bus.div_start === exp_ds) && (bus.div_zero_err === m_dz) && (bus.timeout_err === m_to);
        nvec++;
        if (!ok) begin
            nmis++;
            $display("FAIL cycle @%0t: got hi=%h lo=%h busy=%b rdy=%b ms=%b ds=%b dz=%b to=%b; want hi=%h lo=%h busy=%b rdy=%b ms=%b ds=%b dz=%b to=%b",
                     $time, bus.hi, bus.lo, bus.busy, bus.op_ready, bus.mult_start, bus.div_start,
                     bus.div_zero_err, bus.timeout_err, m_hi, m_lo, m_act, !m_act, exp_ms, exp_ds, m_dz, m_to);
        end
        if (bus.mult_start || bus.div_start) start_cnt++;
    endtask

    // Compare this cycle at the falling edge, then return 2 time units after the next rising edge.
    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] code, input logic [31:0] data);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_data  = data;
        step();
        bus.op_valid = 1'b0;
    endtask

    initial begin
        bus.op_valid = 0; bus.op_code = 0; bus.op_data = 0;
        bus.mult_hi = 0; bus.mult_lo = 0; bus.mult_done = 0;
        bus.div_hi = 0; bus.div_lo = 0; bus.div_done = 0; bus.div_zero = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_hi", bus.hi, 32'h0);
        chk("reset_lo", bus.lo, 32'h0);
        chk("reset_rdy", {31'b0, bus.op_ready}, 32'h1);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);

        // MULT, done 33 cycles after the start cycle; a stray done during start is ignored.
        start_cnt = 0;
        issue(2'd0, 32'h0);
        bus.mult_done = 1; bus.mult_hi = 32'h5555_5555; bus.mult_lo = 32'h6666_6666;
        step();
        bus.mult_done = 0;
        repeat (32) step();
        bus.mult_done = 1; bus.mult_hi = 32'hFFFF_FFFF; bus.mult_lo = 32'hFFFF_FFEB;
        step();
        bus.mult_done = 0;
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
        chk("mult_rdy", {31'b0, bus.op_ready}, 32'h1);
        chk("mult_start_cycles", start_cnt, 1);

        // Back-to-back MTHI then MTLO.
        start_cnt = 0;
        bus.op_valid = 1; bus.op_code = 2; bus.op_data = 32'h1234_5678;
        step();
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        bus.op_code = 3; bus.op_data = 32'hCAFE_BABE;
        step();
        bus.op_valid = 0;
        chk("mtlo_lo", bus.lo, 32'hCAFE_BABE);
        chk("mtlo_hi_kept", bus.hi, 32'h1234_5678);
        chk("mt_no_starts", start_cnt, 0);

        // DIV by zero with prior hi/lo = 1/2.
        issue(2'd2, 32'h1);
        issue(2'd3, 32'h2);
        issue(2'd1, 32'h0);
        repeat (10) step();
        bus.div_done = 1; bus.div_zero = 1; bus.div_hi = 32'h7777_7777; bus.div_lo = 32'h8888_8888;
        step();
        bus.div_done = 0; bus.div_zero = 0;
        chk("dz_err", {31'b0, bus.div_zero_err}, 32'h1);
        chk("dz_hi", bus.hi, 32'h1);
        chk("dz_lo", bus.lo, 32'h2);
        chk("dz_idle", {31'b0, bus.op_ready}, 32'h1);
        step();
        chk("dz_err_pulse", {31'b0, bus.div_zero_err}, 32'h0);

        // MULT timeout: no done ever.
        issue(2'd0, 32'h0);
        repeat (TO) step();
        chk("to_busy_last_wait", {31'b0, bus.busy}, 32'h1);
        step();
        chk("to_err", {31'b0, bus.timeout_err}, 32'h1);
        chk("to_rdy", {31'b0, bus.op_ready}, 32'h1);
        chk("to_hi", bus.hi, 32'h1);
        chk("to_lo", bus.lo, 32'h2);
        step();
        chk("to_err_pulse", {31'b0, bus.timeout_err}, 32'h0);

        // Done on the final wait cycle wins over timeout.
        issue(2'd0, 32'h0);
        repeat (TO) step();
        bus.mult_done = 1; bus.mult_hi = 32'h0000_0ABC; bus.mult_lo = 32'h1357_9BDF;
        step();
        bus.mult_done = 0;
        chk("late_done_hi", bus.hi, 32'h0000_0ABC);
        chk("late_done_lo", bus.lo, 32'h1357_9BDF);
        chk("late_done_no_to", {31'b0, bus.timeout_err}, 32'h0);

        // MTLO held during DIV is dropped, then accepted once idle.
        issue(2'd1, 32'h0);
        bus.op_valid = 1; bus.op_code = 3; bus.op_data = 32'hDEAD_BEEF;
        repeat (5) step();
        bus.div_done = 1; bus.div_zero = 0; bus.div_hi = 32'h3; bus.div_lo = 32'h5;
        step();
        bus.div_done = 0;
        chk("div_hi", bus.hi, 32'h3);
        chk("div_lo_not_mtlo", bus.lo, 32'h5);
        step();
        bus.op_valid = 0;
        chk("held_mtlo_lo", bus.lo, 32'hDEAD_BEEF);
        chk("held_mtlo_hi", bus.hi, 32'h3);

        // Reset mid M_WAIT, then a late done strobe.
        issue(2'd0, 32'h0);
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("rst_mid_hi", bus.hi, 32'h0);
        chk("rst_mid_lo", bus.lo, 32'h0);
        chk("rst_mid_busy", {31'b0, bus.busy}, 32'h0);
        step();
        reset = 1'b0;
        repeat (5) step();
        bus.mult_done = 1; bus.mult_hi = 32'hAAAA_AAAA; bus.mult_lo = 32'hBBBB_BBBB;
        step();
        bus.mult_done = 0;
        chk("rst_late_hi", bus.hi, 32'h0);
        chk("rst_late_lo", bus.lo, 32'h0);
        chk("rst_late_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_late_errs", {30'b0, bus.div_zero_err, bus.timeout_err}, 32'h0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
